// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : uart_rx_if
// Purpose  : Received-word port of the UART receiver (valid/ready plus error pulses).
// Revision : 1.0 - initial release
// =============================================================================
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  frame_err;
    logic                  overrun;

    modport master (output data, valid, frame_err, overrun, input ready);
    modport slave  (input data, valid, frame_err, overrun, output ready);
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : uart_rx
// Purpose  : 8N1 serial receiver, mid-bit sampling, stop-bit check, valid/ready out.
// Revision : 1.0 - initial release
// =============================================================================
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 9600,
    parameter int CLK_FREQ   = 12_000_000
) (
    input  wire       clk,
    input  wire       rstn,
    input  wire       sig,
    uart_rx_if.master bus
);
    localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int CNT_W            = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam int IDX_W            = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  sync1;
    logic                  s;
    logic                  s_d;
    logic                  fell;
    logic                  cnt_zero;
    logic [CNT_W-1:0]      clk_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  ferr_q;
    logic                  ovr_q;
    logic                  load_word;
    logic                  set_ferr;
    logic                  set_ovr;

    assign fell     = s_d & ~s;
    assign cnt_zero = (clk_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (fell) state_nxt = ST_START;
            ST_START: if (cnt_zero) state_nxt = s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (cnt_zero && (bit_idx == IDX_LAST)) state_nxt = ST_STOP;
            ST_STOP:  if (cnt_zero) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Stop-sample outcome; a consumer handshake in the same cycle frees the slot.
    always_comb begin
        load_word = 1'b0;
        set_ferr  = 1'b0;
        set_ovr   = 1'b0;
        if ((state == ST_STOP) && cnt_zero) begin
            if (!s) begin
                set_ferr = 1'b1;
            end else if (!valid_q || bus.ready) begin
                load_word = 1'b1;
            end else begin
                set_ovr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1   <= 1'b1;
            s       <= 1'b1;
            s_d     <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1  <= sig;
            s      <= sync1;
            s_d    <= s;
            ferr_q <= set_ferr;
            ovr_q  <= set_ovr;

            if (load_word) begin
                data_q  <= shift;
                valid_q <= 1'b1;
            end else if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (fell) clk_cnt <= CNT_HALF;
                end
                ST_START: begin
                    if (!cnt_zero) begin
                        clk_cnt <= clk_cnt - CNT_ONE;
                    end else if (!s) begin
                        clk_cnt <= CNT_FULL;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (!cnt_zero) begin
                        clk_cnt <= clk_cnt - CNT_ONE;
                    end else begin
                        shift[bit_idx] <= s;
                        clk_cnt        <= CNT_FULL;
                        if (bit_idx != IDX_LAST) bit_idx <= bit_idx + IDX_ONE;
                    end
                end
                ST_STOP: begin
                    if (!cnt_zero) clk_cnt <= clk_cnt - CNT_ONE;
                end
                default: clk_cnt <= '0;
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_uart_rx
// Purpose  : Scoreboard bench for uart_rx: directed scenarios plus random frames.
// Revision : 1.0 - initial release
// =============================================================================
module tb_uart_rx;
    localparam int DW       = 8;
    localparam int CLK_FREQ = 1_200_000;
    localparam int BAUD     = 100_000;
    localparam int PW       = CLK_FREQ / BAUD;
    localparam int HALF     = PW / 2;
    localparam int LAT      = HALF + 2 + (DW + 1) * PW;
    localparam int FRAME    = (DW + 2) * PW;
    localparam int K_WORD   = 0;
    localparam int K_FERR   = 1;
    localparam int K_OVR    = 2;

    typedef struct {
        int          kind;
        logic [DW-1:0] d;
        int          cyc;
    } ev_t;

    ev_t  expq[$];
    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    logic sig   = 1'b1;
    logic ready = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   held  = 1'b0;
    logic pv    = 1'b0;
    logic pr    = 1'b0;
    logic [DW-1:0] pdata = '0;

    uart_rx_if #(.DATA_WIDTH(DW)) bus ();
    assign bus.ready = ready;

    uart_rx #(
        .DATA_WIDTH(DW),
        .BAUD_RATE (BAUD),
        .CLK_FREQ  (CLK_FREQ)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .sig (sig),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: outcome of a frame is decided by its stop bit and
    // whether an unconsumed word occupies the output when the stop is sampled.
    function automatic void model_frame(input logic [DW-1:0] d, input bit stop_ok,
                                        input int t0, input bit rdy_stop, input bit rdy_static);
        ev_t e;
        e.d   = d;
        e.cyc = t0 + LAT;
        if (!stop_ok) begin
            e.kind = K_FERR;
        end else if (held && !rdy_stop) begin
            e.kind = K_OVR;
        end else begin
            e.kind = K_WORD;
            held   = !rdy_static;
        end
        expq.push_back(e);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ready(input bit r);
        ready = r;
        if (r) held = 1'b0;
    endtask

    task automatic consume();
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        held  = 1'b0;
    endtask

    // Called at posedge+1; the start bit is captured at the next posedge (t0).
    task automatic send_frame(input logic [DW-1:0] d, input bit stop_ok, input bit pulse);
        logic [DW+1:0] bits;
        int t0;
        bits = {stop_ok, d, 1'b0};
        t0   = cyc + 1;
        model_frame(d, stop_ok, t0, pulse || ready, ready && !pulse);
        for (int c = 0; c < FRAME; c++) begin
            sig = bits[c / PW];
            if (pulse && (cyc + 1 == t0 + LAT))     ready = 1'b1;
            if (pulse && (cyc + 1 == t0 + LAT + 1)) ready = 1'b0;
            step(1);
        end
    endtask

    task automatic expect_event(input int kind, input logic [DW-1:0] d);
        ev_t e;
        if (expq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data 0x%0h at cycle %0d, expected none",
                     kind, d, cyc);
        end else begin
            e = expq.pop_front();
            chk_eq("event_kind", kind, e.kind);
            chk_eq("event_cycle", cyc, e.cyc);
            if (e.kind == K_WORD) chk_eq("word_data", d, e.d);
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (bus.frame_err) expect_event(K_FERR, '0);
            if (bus.overrun)   expect_event(K_OVR, '0);
            if (bus.valid && (!pv || pr)) begin
                expect_event(K_WORD, bus.data);
            end else if (bus.valid && pv && !pr) begin
                chk_eq("hold_stable", bus.data, pdata);
            end
            pv    = bus.valid;
            pr    = ready;
            pdata = bus.data;
        end
    end

    initial begin
        logic [DW-1:0] rb;
        bit            rs;

        rstn = 1'b0;
        step(4);
        chk_eq("reset_valid", bus.valid, 0);
        chk_eq("reset_data", bus.data, 0);
        chk_eq("reset_frame_err", bus.frame_err, 0);
        chk_eq("reset_overrun", bus.overrun, 0);
        rstn = 1'b1;
        step(10);

        // Single word, consumer always ready
        set_ready(1'b1);
        send_frame(8'hA5, 1'b1, 1'b0);
        step(5);
        chk_eq("t1_valid_dropped", bus.valid, 0);

        // Back-to-back frames while the consumer stalls
        set_ready(1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        step(5);
        chk_eq("t2_data_kept", bus.data, 8'h3C);
        chk_eq("t2_valid_kept", bus.valid, 1);
        consume();
        step(2);
        chk_eq("t2_valid_after_ready", bus.valid, 0);

        // Bad stop bit, line stuck low, then recovery
        set_ready(1'b1);
        send_frame(8'h55, 1'b0, 1'b0);
        step(200);
        chk_eq("t3_no_valid_low_line", bus.valid, 0);
        sig = 1'b1;
        step(30);
        send_frame(8'h0F, 1'b1, 1'b0);
        step(5);

        // Short glitch on idle line
        sig = 1'b0;
        step(3);
        sig = 1'b1;
        step(40);

        // Reset in the middle of a frame
        sig = 1'b0;
        step(PW);
        sig = 1'b1;
        step(3 * PW);
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk_eq("t5_rst_valid", bus.valid, 0);
            chk_eq("t5_rst_data", bus.data, 0);
            chk_eq("t5_rst_frame_err", bus.frame_err, 0);
            chk_eq("t5_rst_overrun", bus.overrun, 0);
        end
        rstn = 1'b1;
        held = 1'b0;
        step(20);
        send_frame(8'h12, 1'b1, 1'b0);
        step(5);

        // Handshake coincides with next stop sample
        set_ready(1'b0);
        send_frame(8'h01, 1'b1, 1'b0);
        step(10);
        send_frame(8'h02, 1'b1, 1'b1);
        step(3);
        chk_eq("t6_data_new", bus.data, 8'h02);
        chk_eq("t6_valid_kept", bus.valid, 1);
        consume();
        step(3);

        // Random frames with random stop errors and consumer policy
        for (int n = 0; n < 24; n++) begin
            sig = 1'b1;
            step($urandom_range(2, 30));
            if (held && ($urandom_range(0, 1) == 0)) consume();
            set_ready(($urandom_range(0, 1) == 1));
            rb = DW'($urandom);
            rs = ($urandom_range(0, 5) != 0);
            send_frame(rb, rs, 1'b0);
        end

        sig = 1'b1;
        step(30);
        chk_eq("queue_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
